// File: rtl/pixel_readout_pkg.sv
// Shared types and constants for the pixel readout buffer.
// Entry layout is {sof, eof, data}, with sof as the MSB.
package pixel_readout_pkg;

  localparam int PIXEL_WIDTH = 8;
  localparam int FRAME_COUNT_WIDTH = 16;

  typedef struct packed {
    logic                   sof;
    logic                   eof;
    logic [PIXEL_WIDTH-1:0] data;
  } readout_entry_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/readout_fifo_mem.sv
// FIFO storage array with one write port and one asynchronous read port.
// Entries are deliberately left unreset; occupancy is tracked by the controller.
module readout_fifo_mem #(
  parameter int width = 10,
  parameter int depth = 8,
  parameter int addr_width = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [width-1:0]      wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [width-1:0]      rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_readout_fifo.sv
// Tags readout words with frame position and buffers them on a valid/ready stream.
// Define PIXEL_READOUT_SUM_EN to add the per-frame pixel sum outputs.
module pixel_readout_fifo
  import pixel_readout_pkg::*;
#(
  parameter int pixel_count = 4,
  parameter int counter_width = 8,
  parameter int fifo_depth = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read,
  input  logic [counter_width-1:0]     pixel_in,
  input  logic                         out_ready,
  input  logic                         clear_overflow,
  output logic                         out_valid,
  output logic [counter_width-1:0]     out_data,
  output logic                         out_sof,
  output logic                         out_eof,
  output logic [$clog2(fifo_depth):0]  level,
  output logic                         overflow,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count
`ifdef PIXEL_READOUT_SUM_EN
  ,
  output logic [counter_width+$clog2(pixel_count)-1:0] frame_sum,
  output logic                                         frame_sum_valid
`endif
);

  localparam int AW = $clog2(fifo_depth);
  localparam int LW = AW + 1;
  localparam int IW = idx_bits(pixel_count);
  localparam int EW = counter_width + 2;
  localparam logic [IW-1:0] LAST = IW'(pixel_count - 1);
  localparam logic [LW-1:0] FULL = LW'(fifo_depth);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [IW-1:0] idx;
  logic [EW-1:0] head;
  logic [EW-1:0] hold;
  logic [EW-1:0] wdata;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic          last;

  assign full      = (level == FULL);
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign push      = read && (!full || pop);
  assign drop      = read && !push;
  assign last      = (idx == LAST);
  assign wdata     = {idx == '0, last, pixel_in};

  readout_fifo_mem #(
    .width(EW),
    .depth(fifo_depth)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(rd_ptr),
    .rdata(head)
  );

  // hold keeps the last presented head so outputs stay put once empty
  assign {out_sof, out_eof, out_data} = out_valid ? head : hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      hold   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (out_valid) hold <= head;
    end
  end

  // index advances on dropped words too, keeping framing aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      frame_count <= '0;
    end else if (read) begin
      if (last) begin
        idx         <= '0;
        frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef PIXEL_READOUT_SUM_EN
  localparam int SW = counter_width + $clog2(pixel_count);

  logic [SW-1:0] acc;
  logic [SW-1:0] acc_next;

  assign acc_next = acc + SW'(pixel_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc             <= '0;
      frame_sum       <= '0;
      frame_sum_valid <= 1'b0;
    end else begin
      frame_sum_valid <= 1'b0;
      if (read) begin
        if (last) begin
          acc             <= '0;
          frame_sum       <= acc_next;
          frame_sum_valid <= 1'b1;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_readout_fifo.sv
// Scoreboard bench for pixel_readout_fifo against a queue-based reference model.
// Sum outputs are checked when PIXEL_READOUT_SUM_EN is defined.
module tb_pixel_readout_fifo;
  import pixel_readout_pkg::*;

  localparam int PC = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic        out_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] frame_count;
`ifdef PIXEL_READOUT_SUM_EN
  logic [9:0]  frame_sum;
  logic        frame_sum_valid;
`endif

  pixel_readout_fifo #(
    .pixel_count(PC),
    .counter_width(8),
    .fifo_depth(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read(read),
    .pixel_in(pixel_in),
    .out_ready(out_ready),
    .clear_overflow(clear_overflow),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sof(out_sof),
    .out_eof(out_eof),
    .level(level),
    .overflow(overflow),
    .frame_count(frame_count)
`ifdef PIXEL_READOUT_SUM_EN
    ,
    .frame_sum(frame_sum),
    .frame_sum_valid(frame_sum_valid)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  bit en = 0;

  readout_entry_t m_q[$];
  readout_entry_t sb[$];
  readout_entry_t m_hold;
  int          m_idx;
  bit          m_ovf;
  bit [15:0]   m_fc;
  int          m_acc;
  int          m_sum;
  bit          m_sumv;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  task automatic model(input bit r, input bit [7:0] px, input bit rdy,
                       input bit clr, input bit rst);
    bit pop, push;
    readout_entry_t e;
    if (rst) begin
      m_q.delete();
      sb.delete();
      m_hold = '0;
      m_idx = 0;
      m_ovf = 0;
      m_fc = 0;
      m_acc = 0;
      m_sum = 0;
      m_sumv = 0;
      return;
    end
    pop = (m_q.size() > 0) && rdy;
    if (m_q.size() > 0) m_hold = m_q[0];
    push = r && (m_q.size() < DEPTH || pop);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      e.sof = (m_idx == 0);
      e.eof = (m_idx == PC - 1);
      e.data = px;
      m_q.push_back(e);
      sb.push_back(e);
    end
    if (r && !push) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_sumv = 0;
    if (r) begin
      m_acc += px;
      if (m_idx == PC - 1) begin
        m_idx = 0;
        m_fc++;
        m_sum = m_acc;
        m_acc = 0;
        m_sumv = 1;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic step(input bit r, input bit [7:0] px, input bit rdy,
                      input bit clr = 0, input bit rst = 0);
    read = r;
    pixel_in = px;
    out_ready = rdy;
    clear_overflow = clr;
    reset = rst;
    @(posedge clk);
    model(r, px, rdy, clr, rst);
    en = 1;
    #1;
  endtask

  always @(negedge clk) begin
    if (en) begin
      check("level", level, m_q.size());
      check("out_valid", out_valid, m_q.size() != 0);
      check("overflow", overflow, m_ovf);
      check("frame_count", frame_count, m_fc);
`ifdef PIXEL_READOUT_SUM_EN
      check("sum_valid", frame_sum_valid, m_sumv);
      check("frame_sum", frame_sum, m_sum);
`endif
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 0, 1);
        end else begin
          check("data", out_data, sb[0].data);
          check("sof", out_sof, sb[0].sof);
          check("eof", out_eof, sb[0].eof);
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        check("hold_data", out_data, m_hold.data);
        check("hold_sof", out_sof, m_hold.sof);
        check("hold_eof", out_eof, m_hold.eof);
      end
    end
  end

  initial begin
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    // single frame with a free-running consumer
    step(1, 10, 1);
    step(1, 20, 1);
    step(1, 30, 1);
    step(1, 40, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    check("t1_frames", frame_count, 1);
    check("t1_ovf", overflow, 0);
    // nine reads into a stalled consumer
    for (int i = 0; i < 9; i++) step(1, 8'(100 + i), 0);
    check("t2_level", level, 8);
    check("t2_ovf", overflow, 1);
    for (int i = 0; i < 9; i++) step(0, 0, 1);
    step(0, 0, 1, 1);
    check("t2_clear", overflow, 0);
    // push and pop together while full
    for (int i = 0; i < 8; i++) step(1, 8'(150 + i), 0);
    step(1, 77, 1);
    check("t3_level", level, 8);
    check("t3_ovf", overflow, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    // reset mid-frame
    step(1, 1, 0);
    step(1, 2, 0);
    step(0, 0, 0, 0, 1);
    check("t4_valid", out_valid, 0);
    check("t4_level", level, 0);
    step(1, 55, 0);
    check("t4_data", out_data, 55);
    check("t4_sof", out_sof, 1);
    step(0, 0, 1);
    // frame wrap with a drop in the middle of a frame
    for (int i = 0; i < 3; i++) step(1, 8'(60 + i), 0);
    for (int i = 0; i < 4; i++) step(1, 8'(70 + i), 0);
    step(1, 80, 0);
    step(1, 81, 1);
    step(1, 82, 0);
    step(1, 83, 0);
    check("t5_ovf", overflow, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(90 + i), 1);
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    check("t5_frames", frame_count, m_fc);
    // per-frame sums
    step(0, 0, 1, 1, 1);
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 1);
`ifdef PIXEL_READOUT_SUM_EN
    check("t6_sum10", frame_sum, 10);
    check("t6_pulse", frame_sum_valid, 1);
`endif
    for (int i = 0; i < 4; i++) step(1, 255, 1);
`ifdef PIXEL_READOUT_SUM_EN
    check("t6_sum1020", frame_sum, 1020);
`endif
    step(0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(3, 0) != 0, 8'($urandom),
           $urandom_range(1, 0) == 1, $urandom_range(9, 0) == 0,
           $urandom_range(99, 0) == 0);
    end
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    check("drain_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_readout_fifo.md
Name: pixel_readout_fifo

Overview:
- Downstream consumer of the pixel array readout.
- Captures each `pixel_out` word qualified by `read`, tags it with frame position (start/end of frame), and buffers it in a FIFO.
- Presents the buffered words on a valid/ready stream to the host interface.
- Decouples the fixed-rate sensor readout from a back-pressuring consumer and flags lost pixels.

Parameters:
- `pixel_count`, 4, pixels per frame (array_width*array_height); ≥2.
- `counter_width`, 8, pixel word width (matches ADC counter width).
- `fifo_depth`, 8, FIFO entries; power of two, ≥2.

Ports:
- `clk` input 1 system clock; all logic on rising edge.
- `reset` input 1 synchronous, active-high reset.
- `read` input 1 pixel word valid this cycle (from data path).
- `pixel_in` input counter_width pixel value (array `pixel_out`).
- `out_ready` input 1 consumer accepts head word.
- `clear_overflow` input 1 clears sticky overflow flag.
- `out_valid` output 1 head word valid.
- `out_data` output counter_width head pixel value.
- `out_sof` output 1 head word is pixel index 0.
- `out_eof` output 1 head word is pixel index pixel_count-1.
- `level` output $clog2(fifo_depth)+1 current occupancy.
- `overflow` output 1 sticky: a pixel was dropped.
- `frame_count` output 16 completed input frames, wraps at 65535→0.

Behaviour:
- Reset (sync, `reset`=1 at edge):
  - FIFO flushed; `level`=0, `out_valid`=0, `out_data`=0, `out_sof`=0, `out_eof`=0.
  - `overflow`=0, `frame_count`=0, pixel index=0.
  - Reset mid-frame discards partial frame; the next `read` is tagged SOF.
- Push: `push` = `read` && (!full || pop).
  - Stored entry = {sof = idx==0, eof = idx==pixel_count-1, data = `pixel_in`}.
- Pixel index:
  - Advances on every `read`, accepted or dropped, so framing stays aligned.
  - Wraps from pixel_count-1 to 0.
  - On wrap, `frame_count` increments (one cycle after the final `read`).
- Drop: `read`=1 while full and no pop → word discarded; `overflow` set next cycle.
- `overflow`:
  - Cleared by `clear_overflow`=1.
  - A simultaneous drop and clear leaves `overflow`=1 (set wins).
- Pop: `pop` = `out_valid` && `out_ready`. First-word-fall-through:
  - `out_valid` = (`level`!=0).
  - `out_data`/`out_sof`/`out_eof` reflect the head entry while valid; they hold their last value when empty.
- Latency:
  - A word pushed into an empty FIFO appears on `out_valid` the next cycle.
  - No same-cycle bypass.
- Simultaneous push+pop:
  - When full: accepted, `level` unchanged.
  - When empty: pop is impossible (`out_valid`=0); push only.
- `level` updates each cycle: +1 push only, −1 pop only, unchanged both/neither.
- Pointers are $clog2(fifo_depth) bits and wrap naturally; full/empty derived from `level`.
- `out_ready` may toggle freely; `out_data` must stay stable while `out_valid`=1 and `out_ready`=0.

Optional Feature:
- Macro: `PIXEL_READOUT_SUM_EN`.
- Defined:
  - Adds output `frame_sum` (counter_width+$clog2(pixel_count) bits) and output `frame_sum_valid` (1 bit).
  - Accumulates every `read` word, including dropped words.
  - On the final pixel of a frame, registers the total into `frame_sum` and pulses `frame_sum_valid` for one cycle, aligned with the `frame_count` increment.
  - Accumulator then restarts at 0.
  - Reset clears `frame_sum`, `frame_sum_valid` and the accumulator.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package `pixel_readout_pkg`:
  - typedef `readout_entry_t` packed struct {sof, eof, data[counter_width]}, using the default width constant `PIXEL_WIDTH`=8.
  - `FRAME_COUNT_WIDTH`=16.
- Sub-module `readout_fifo_mem`:
  - Parameterised storage array with write port and asynchronous read port, indexed by pointer.
  - Control, tagging, counters and the optional sum stay in `pixel_readout_fifo`.

Test Plan:
- Single frame, `out_ready`=1, `pixel_count`=4, `read` on 4 cycles with values 10,20,30,40:
  - Output stream 10(sof),20,30,40(eof), each one cycle after input.
  - `frame_count`=1; `overflow`=0.
- `out_ready`=0, 9 consecutive `read` with `fifo_depth`=8:
  - `level`=8, `overflow`=1 after the 9th.
  - Releasing ready drains the first 8 words in order.
  - `clear_overflow` then returns `overflow` to 0.
- FIFO full, `read`=1 and `out_ready`=1 same cycle:
  - Word accepted, `level` stays 8, no overflow.
  - Drained order preserved.
- Reset asserted after 2 of 4 pixels:
  - `out_valid`=0, `level`=0 next cycle.
  - Next `read` value 55 emerges with `out_sof`=1.
- Index wrap across 3 frames with back-pressure dropping pixel 2 of frame 2:
  - Frame 3 pixel 0 still tagged sof.
  - `frame_count`=3.
- With `PIXEL_READOUT_SUM_EN`, frame 1,2,3,4:
  - `frame_sum`=10 with a one-cycle `frame_sum_valid` pulse.
  - Next frame 255×4 gives 1020.
